// File: rtl/config_pkg.sv
// Shared types and helpers for the configuration source arbiter.
// Holds the FSM state encoding, the priority mode constants and a constant clog2.
package config_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/config_rr_pick.sv
// Combinational masked priority picker: first eligible index at or after pointer, wrapping.
// A pointer of zero gives plain lowest-index-wins fixed priority.
module config_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] pointer,
  output logic [N-1:0]  winner,
  output logic [PW-1:0] winner_idx,
  output logic          found
);

  // Two passes: indices at/after the pointer first, then wrap around from zero.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && eligible[i] && (i >= int'(pointer))) begin
        winner[i]  = 1'b1;
        winner_idx = PW'(i);
        found      = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && eligible[i]) begin
        winner[i]  = 1'b1;
        winner_idx = PW'(i);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/config_source_arbiter.sv
// N-channel arbiter granting one configuration write source a locked session at a time.
// Forwarded strobe/data are registered (1-cycle latency); every release passes through a 1-cycle DRAIN.
module config_source_arbiter
  import config_pkg::*;
#(
  parameter int NumberOfChannels = 4,
  parameter int DataWidth        = 32,
  parameter int PriorityMode     = PRIO_FIXED,
  parameter int IdleTimeout      = 1023,
  parameter int CountWidth       = 16
) (
  input  logic                                  CLK,
  input  logic                                  Resetn,
  input  logic [NumberOfChannels-1:0]           ChActive,
  input  logic [NumberOfChannels*DataWidth-1:0] ChWriteData,
  input  logic [NumberOfChannels-1:0]           ChWriteStrobe,
  output logic [DataWidth-1:0]                  WriteData,
  output logic                                  WriteStrobe,
  output logic                                  SessionActive,
  output logic                                  SessionStart,
  output logic [NumberOfChannels-1:0]           Grant,
  output logic [CountWidth-1:0]                 WordCount,
  output logic                                  TimeoutFlag
);

  localparam int N  = NumberOfChannels;
  localparam int PW = (N > 1) ? clog2(N) : 1;
  localparam int IW = (IdleTimeout > 0) ? clog2(IdleTimeout + 1) : 1;

  localparam bit             RrMode    = (PriorityMode == PRIO_RR);
  localparam bit             TimeoutOn = (IdleTimeout != 0);
  localparam logic [IW-1:0]  IdleMax   = IW'(IdleTimeout);
  localparam logic [PW-1:0]  LastIdx   = PW'(N - 1);

  state_t         state_q, state_d;
  logic [N-1:0]   mask_q, mask_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  owner_q;
  logic [IW-1:0]  idle_q;

  logic [N-1:0]   eligible;
  logic [PW-1:0]  pick_ptr;
  logic [N-1:0]   pick_onehot;
  logic [PW-1:0]  pick_idx;
  logic           pick_any;

  logic                 own_act;
  logic                 own_stb;
  logic [DataWidth-1:0] own_dat;
  logic                 lower_req;

  logic rel_drop, rel_tmo, rel_pre;
  logic release_now, timeout_now, start_now;

  assign eligible = ChActive & ~mask_q;
  assign pick_ptr = RrMode ? ptr_q : '0;

  config_rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .eligible   (eligible),
    .pointer    (pick_ptr),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .found      (pick_any)
  );

  // Owner-side view of the source ports, plus any eligible request above the owner.
  always_comb begin
    own_act   = 1'b0;
    own_stb   = 1'b0;
    own_dat   = '0;
    lower_req = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (owner_q == PW'(i)) begin
        own_act = ChActive[i];
        own_stb = ChWriteStrobe[i];
        own_dat = ChWriteData[i*DataWidth +: DataWidth];
      end
      if ((i < int'(owner_q)) && eligible[i]) lower_req = 1'b1;
    end
  end

  assign rel_drop = !own_act;
  assign rel_tmo  = TimeoutOn && !own_stb && (idle_q == IdleMax);
  assign rel_pre  = !RrMode && lower_req;

  always_comb begin
    state_d     = state_q;
    release_now = 1'b0;
    timeout_now = 1'b0;
    start_now   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d   = ST_OWNED;
          start_now = 1'b1;
        end
      end
      ST_OWNED: begin
        if (rel_drop) begin
          state_d     = ST_DRAIN;
          release_now = 1'b1;
        end else if (rel_tmo) begin
          state_d     = ST_DRAIN;
          release_now = 1'b1;
          timeout_now = 1'b1;
        end else if (rel_pre) begin
          state_d     = ST_DRAIN;
          release_now = 1'b1;
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A timed-out channel stays masked until it drops its request.
  always_comb begin
    mask_d = mask_q & ChActive;
    if (timeout_now) mask_d[owner_q] = 1'b1;
    ptr_d = ptr_q;
    if (release_now && RrMode) ptr_d = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      owner_q       <= '0;
      idle_q        <= '0;
      WriteData     <= '0;
      WriteStrobe   <= 1'b0;
      SessionActive <= 1'b0;
      SessionStart  <= 1'b0;
      Grant         <= '0;
      WordCount     <= '0;
      TimeoutFlag   <= 1'b0;
    end else begin
      SessionStart <= start_now;
      WriteStrobe  <= (state_q == ST_OWNED) && own_stb;
      if ((state_q == ST_OWNED) && own_stb) WriteData <= own_dat;

      if (start_now) begin
        owner_q       <= pick_idx;
        Grant         <= pick_onehot;
        SessionActive <= 1'b1;
        WordCount     <= '0;
        idle_q        <= '0;
        TimeoutFlag   <= 1'b0;
      end else if (state_q == ST_OWNED) begin
        if (own_stb) begin
          idle_q <= '0;
          if (WordCount != '1) WordCount <= WordCount + 1'b1;
        end else if (TimeoutOn && (idle_q != IdleMax)) begin
          idle_q <= idle_q + 1'b1;
        end
        if (release_now) begin
          Grant         <= '0;
          SessionActive <= 1'b0;
        end
        if (timeout_now) TimeoutFlag <= 1'b1;
      end
    end
  end

endmodule

// File: doc/config_source_arbiter.md
Name: config_source_arbiter

Overview:
Parametrised N-channel arbiter for configuration write sources such as UART, bitbang, CPU self-write and future JTAG. It is the successor to the fixed two-level priority mux in front of the fabric configuration FSM. It adds:
- selectable fixed or round-robin priority
- session locking with controlled preemption
- an idle timeout
- registered outputs and per-session word counting
It sits between the source ports and the frame configuration FSM.

Parameters:
NumberOfChannels, 4, number of configuration sources; channel 0 has the highest fixed priority.
DataWidth, 32, width of the configuration write word.
PriorityMode, 0, 0 = fixed priority with preemption; 1 = round-robin with no preemption.
IdleTimeout, 1023, number of cycles a granted channel may be active without a strobe before it is released; 0 disables the timeout.
CountWidth, 16, width of WordCount.

Ports:
CLK  input  1  system clock, all logic on the rising edge
Resetn  input  1  asynchronous active-low reset
ChActive  input  NumberOfChannels  per-channel session request, level
ChWriteData  input  NumberOfChannels*DataWidth  packed data; channel i occupies bits [i*DataWidth +: DataWidth]
ChWriteStrobe  input  NumberOfChannels  per-channel one-cycle write strobe
WriteData  output  DataWidth  registered data to the configuration FSM
WriteStrobe  output  1  registered strobe to the configuration FSM
SessionActive  output  1  high while in OWNED; drives the configuration FSM Reset input
SessionStart  output  1  one-cycle pulse on the first OWNED cycle of every grant
Grant  output  NumberOfChannels  one-hot owner, all zero when not OWNED
WordCount  output  CountWidth  strobes forwarded in the current session, saturating
TimeoutFlag  output  1  sticky; set on timeout release, cleared on the next SessionStart

Behaviour:
Reset values:
- Resetn low asynchronously forces: state IDLE; all outputs 0; round-robin pointer 0; timeout mask 0; idle counter 0.

States:
- IDLE: eligible = ChActive & ~mask. If any channel is eligible, select a winner and go to OWNED on the next edge.
  - Mode 0 winner: lowest eligible index.
  - Mode 1 winner: first eligible index at or after the pointer, wrapping modulo NumberOfChannels.
- OWNED: Grant and SessionActive high. SessionStart pulses in the first OWNED cycle, and WordCount and the idle counter clear in that cycle. From the granted channel:
  - ChWriteData is registered to WriteData.
  - ChWriteStrobe is registered to WriteStrobe, so latency is exactly 1 cycle.
  - Strobes from non-granted channels are ignored.
- DRAIN: lasts 1 cycle. WriteStrobe is 0 and SessionActive is 0, which gives the configuration FSM a reset edge. Grant is zero. Next state is IDLE.

Leaving OWNED (priority order when several conditions hold in the same cycle):
1. Granted ChActive low -> DRAIN.
2. Timeout: the idle counter reaches IdleTimeout with no granted strobe -> DRAIN, TimeoutFlag set, granted channel's mask bit set.
3. Mode 0 only: any eligible index lower than the owner -> DRAIN (preemption). The preempting channel wins in IDLE on the following cycle.
- A granted strobe arriving in the same cycle as any exit condition is still forwarded.

Round-robin pointer:
- On each release in mode 1, the pointer becomes owner+1, wrapping.

Timeout mask:
- A mask bit clears when the corresponding ChActive goes low.

Idle counter:
- Increments each OWNED cycle without a granted strobe and resets on a granted strobe.
- Its width is clog2(IdleTimeout+1).

Strobe timing:
- A strobe arriving on the cycle a channel is selected in IDLE is dropped, because the grant is not yet registered.
- Sources must wait for SessionStart (visible to firmware) or tolerate a 2-cycle start latency.

WordCount:
- Increments on each forwarded strobe and saturates at all-ones.
- Holds its value through DRAIN and IDLE until the next SessionStart.

WriteData:
- Holds its last value when there is no strobe. It is not cleared outside reset.

Decomposition:
- Shared package config_pkg holds:
  - the state encoding (IDLE, OWNED, DRAIN)
  - the PRIO_FIXED and PRIO_RR mode constants
  - the clog2 function
- One sub-module, config_rr_pick: combinational masked priority picker taking eligible and pointer and returning a one-hot winner. It is reused for mode 0 with pointer = 0.

Test Plan:
1. Reset and idle: hold Resetn low mid-session with Ch1 owning, then release it -> all outputs 0 and state IDLE; Grant = 0000 with no request.
2. Fixed priority and preemption (mode 0):
   - Ch2 active, strobes 0xA5A5A5A5 -> WriteData equals it one cycle later and Grant = 0100.
   - Assert Ch0 active -> one DRAIN cycle (SessionActive 0), then Grant = 0001, SessionStart pulses, WordCount resets to 0.
3. Round-robin (mode 1): all four channels active, each released in turn -> grant order 0,1,2,3,0; no preemption while owned.
4. Timeout: IdleTimeout = 8, Ch1 active with no strobes -> release after 8 idle cycles, TimeoutFlag = 1, Ch1 not re-granted until ChActive[1] toggles low.
5. Counting and filtering: owner Ch3 sends 5 strobes while Ch1 strobes concurrently -> WordCount = 5 and only Ch3 data appears; with CountWidth = 2, 5 strobes -> WordCount saturates at 3.
6. Edge case: a strobe on the same cycle the owner's ChActive falls -> it is still forwarded, then DRAIN, then IDLE.
